// File: rtl/ucode_sequencer.sv
// Microcode sequencer: instruction register, phase counter, fetch/exec/wait/halt control, IRQ injection.
// All outputs registered (1 cycle); WAIT microcommands stall everything until mem_ready.
module ucode_sequencer #(
  parameter int UC_END_BIT   = 27,
  parameter int UC_WAIT_BIT  = 26,
  parameter int UC_LATCH_BIT = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [27:0] ucommand,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        halt,
  input  logic        _wait,
  input  logic        ei,
  input  logic        di,
  input  logic        rti,
  input  logic        irq_req,
  input  logic [8:0]  irq_vec,
  output logic [15:0] instruction,
  output logic [2:0]  phase,
  output logic        fetch,
  output logic        exc_triggered,
  output logic        int_en,
  output logic        halted,
  output logic        ucode_err
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WAITING, S_HALTED} state_t;

  state_t state;
  logic   stall;
  logic   uc_end;
  logic   last_phase;
  logic   int_en_upd;
  logic   unused_ucmd;

  assign stall       = ucommand[UC_WAIT_BIT] & ~mem_ready;
  assign uc_end      = ucommand[UC_END_BIT];
  assign last_phase  = (phase == 3'd7);
  assign unused_ucmd = ^ucommand;

  // rti is applied after di, so only a simultaneous ei+di resolves to disabled
  always_comb begin
    int_en_upd = int_en;
    if (ei)  int_en_upd = 1'b1;
    if (di)  int_en_upd = 1'b0;
    if (rti) int_en_upd = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_FETCH;
      phase         <= 3'd0;
      fetch         <= 1'b1;
      instruction   <= 16'h0000;
      exc_triggered <= 1'b0;
      int_en        <= 1'b0;
      halted        <= 1'b0;
      ucode_err     <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (ucommand[UC_LATCH_BIT] && mem_ready)
            instruction <= mem_rdata;
          if (!stall) begin
            if (uc_end) begin
              phase <= 3'd0;
              state <= S_EXEC;
              fetch <= 1'b0;
            end else if (last_phase) begin
              ucode_err <= 1'b1;
              phase     <= 3'd0;
            end else begin
              phase <= phase + 3'd1;
            end
          end
        end

        S_EXEC: begin
          if (!stall) begin
            if (uc_end) begin
              phase         <= 3'd0;
              exc_triggered <= 1'b0;
              int_en        <= int_en_upd;
              if (halt) begin
                state  <= S_HALTED;
                halted <= 1'b1;
              end else if (_wait) begin
                state <= S_WAITING;
              end else if (irq_req && int_en_upd) begin
                instruction   <= {3'b100, 4'b0000, irq_vec};
                exc_triggered <= 1'b1;
                int_en        <= 1'b0;
              end else begin
                state <= S_FETCH;
                fetch <= 1'b1;
              end
            end else if (last_phase) begin
              // runaway sequence: abandon it, ignore enable strobes, refetch
              ucode_err     <= 1'b1;
              phase         <= 3'd0;
              exc_triggered <= 1'b0;
              state         <= S_FETCH;
              fetch         <= 1'b1;
            end else begin
              phase <= phase + 3'd1;
            end
          end
        end

        S_WAITING: begin
          if (irq_req && int_en) begin
            instruction   <= {3'b100, 4'b0000, irq_vec};
            exc_triggered <= 1'b1;
            int_en        <= 1'b0;
            state         <= S_EXEC;
          end
        end

        S_HALTED: begin
        end
      endcase
    end
  end

endmodule
